// File: rtl/lpddr5_ca_cmd_decoder.sv
// lpddr5_ca_cmd_decoder: decodes the LPDDR5 CA bus into one-cycle commands with pair, CAS and refresh checks
module lpddr5_ca_cmd_decoder #(
    parameter int T_REFI_MAX = 3900,
    parameter int T_ACT_REF  = 6,
    parameter int CAS_WINDOW = 8
) (
    input  logic        ck_t,
    input  logic        ddr_reset,
    input  logic        cs,
    input  logic [6:0]  ca,
    output logic        cmd_valid,
    output logic [4:0]  cmd_code,
    output logic [13:0] cmd_arg,
    output logic        cmd_cas,
    output logic        cas_armed,
    output logic        err_seq,
    output logic        err_cas_orphan,
    output logic        err_ref_after_act,
    output logic        err_ref_interval
);
    localparam int RW = $clog2(T_REFI_MAX + 1);
    localparam int CW = $clog2(CAS_WINDOW + 1);
    localparam int AW = $clog2(T_ACT_REF + 1);
    localparam logic [4:0] C_ACT = 5'd1;
    localparam logic [4:0] C_REF = 5'd3;
    localparam logic [4:0] C_CAS = 5'd9;
    localparam logic [4:0] C_MRW = 5'd11;
    localparam logic [4:0] C_ILL = 5'd31;

    typedef enum logic [1:0] {IDLE, WAIT_ACT2, WAIT_MRW2} state_t;

    state_t      state, nxt_state;
    logic [6:0]  first_ca;
    logic [4:0]  dec_code, nxt_code;
    logic [13:0] nxt_arg;
    logic        act1, act2, mrw1, mrw2, pair_ok;
    logic        is_cas, is_ref, consume, cas_last, refi_last;
    logic [CW-1:0] cas_cnt;
    logic [AW-1:0] act_cnt;
    logic [RW-1:0] ref_cnt;

    // single-cycle opcodes; code 0 means nothing to emit
    always_comb begin
        dec_code = 5'd0;
        if (cs)
            casez (ca)
                7'b0000000: dec_code = 5'd0;
                7'b11?????: dec_code = C_ACT;
                7'b0001111: dec_code = 5'd2;
                7'b0001110: dec_code = C_REF;
                7'b011????: dec_code = 5'd4;
                7'b0010???: dec_code = 5'd5;
                7'b010????: dec_code = 5'd6;
                7'b100????: dec_code = 5'd7;
                7'b101????: dec_code = 5'd8;
                7'b0011???: dec_code = C_CAS;
                7'b000011?: dec_code = 5'd10;
                7'b0001101, 7'b000100?: dec_code = C_MRW;
                7'b0001100: dec_code = 5'd12;
                7'b0001011: dec_code = 5'd13;
                7'b0000001: dec_code = 5'd14;
                7'b0000011: dec_code = 5'd15;
                7'b0000010: dec_code = 5'd16;
                default:    dec_code = C_ILL;
            endcase
    end

    assign act1 = cs && ca[6:4] == 3'b111;
    assign act2 = cs && ca[6:4] == 3'b110;
    assign mrw1 = cs && ca == 7'b0001101;
    assign mrw2 = cs && ca[6:1] == 6'b000100;
    assign pair_ok = (state == WAIT_ACT2 && act2) || (state == WAIT_MRW2 && mrw2);
    // a broken pair falls through and this edge is decoded as if from IDLE
    assign nxt_code = pair_ok ? (state == WAIT_ACT2 ? C_ACT : C_MRW)
                    : (act1 || mrw1) ? 5'd0
                    : (act2 || mrw2) ? C_ILL : dec_code;
    assign nxt_arg = pair_ok ? {first_ca, ca} : {7'b0, ca};
    assign nxt_state = pair_ok ? IDLE : act1 ? WAIT_ACT2 : mrw1 ? WAIT_MRW2 : IDLE;
    assign is_cas = nxt_code == C_CAS;
    assign is_ref = nxt_code == C_REF;
    assign consume = cas_armed && nxt_code >= 5'd4 && nxt_code <= 5'd8;
    assign cas_last = cas_cnt == CW'(1);
    assign refi_last = ref_cnt == RW'(T_REFI_MAX - 1);

    always_ff @(posedge ck_t or posedge ddr_reset) begin
        if (ddr_reset) begin
            state <= IDLE;
            first_ca <= '0;
            cmd_valid <= 1'b0;
            cmd_code <= '0;
            cmd_arg <= '0;
            cmd_cas <= 1'b0;
            err_seq <= 1'b0;
            cas_armed <= 1'b0;
            cas_cnt <= '0;
            err_cas_orphan <= 1'b0;
            act_cnt <= '0;
            err_ref_after_act <= 1'b0;
            ref_cnt <= '0;
            err_ref_interval <= 1'b0;
        end else begin
            state <= nxt_state;
            first_ca <= (act1 || mrw1) ? ca : first_ca;
            cmd_valid <= nxt_code != 5'd0;
            cmd_code <= nxt_code;
            cmd_arg <= nxt_code != 5'd0 ? nxt_arg : '0;
            cmd_cas <= consume;
            err_seq <= state != IDLE && !pair_ok;
            cas_armed <= is_cas || (cas_armed && !consume && !cas_last);
            cas_cnt <= is_cas ? CW'(CAS_WINDOW) : cas_armed ? cas_cnt - 1'b1 : cas_cnt;
            err_cas_orphan <= cas_armed && !is_cas && !consume && cas_last;
            act_cnt <= nxt_code == C_ACT ? AW'(T_ACT_REF) : act_cnt != '0 ? act_cnt - 1'b1 : act_cnt;
            err_ref_after_act <= is_ref && act_cnt != '0;
            ref_cnt <= (is_ref || refi_last) ? '0 : ref_cnt + 1'b1;
            err_ref_interval <= refi_last && !is_ref;
        end
    end
endmodule

// File: tb/tb_lpddr5_ca_cmd_decoder.sv
// tb_lpddr5_ca_cmd_decoder: directed and random CA traffic checked against a behavioural scoreboard model
module tb_lpddr5_ca_cmd_decoder;
    localparam int P_REFI = 20;
    localparam int P_ACTREF = 6;
    localparam int P_CASWIN = 8;
    localparam logic [6:0] NOP = 7'b0000000;
    localparam logic [6:0] REF = 7'b0001110;
    localparam logic [6:0] CAS = 7'b0011000;
    localparam logic [6:0] SWEEP [26] = '{
        7'b0001111, 7'b0001110, 7'b0110101, 7'b0010011, 7'b0101010, 7'b1001111, 7'b1010001,
        7'b0011101, 7'b0000110, 7'b0000111, 7'b0001100, 7'b0001011, 7'b0000001, 7'b0000011,
        7'b0000010, 7'b0001010, 7'b0000100, 7'b0000101, 7'b1100000, 7'b0001000, 7'b0001101,
        7'b0001001, 7'b0001101, 7'b1110001, 7'b1101111, 7'b0000000};

    logic ck_t = 1'b0, ddr_reset = 1'b1, cs = 1'b0;
    logic [6:0] ca = '0;
    logic cmd_valid, cmd_cas, cas_armed, err_seq, err_cas_orphan, err_ref_after_act, err_ref_interval;
    logic [4:0] cmd_code;
    logic [13:0] cmd_arg;

    lpddr5_ca_cmd_decoder #(.T_REFI_MAX(P_REFI), .T_ACT_REF(P_ACTREF), .CAS_WINDOW(P_CASWIN)) dut (
        .ck_t(ck_t), .ddr_reset(ddr_reset), .cs(cs), .ca(ca),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg(cmd_arg), .cmd_cas(cmd_cas),
        .cas_armed(cas_armed), .err_seq(err_seq), .err_cas_orphan(err_cas_orphan),
        .err_ref_after_act(err_ref_after_act), .err_ref_interval(err_ref_interval));

    always #5 ck_t = ~ck_t;

    typedef struct packed {
        logic v; logic [4:0] code; logic [13:0] arg;
        logic cas, armed, seq, orphan, raa, rint;
    } obs_t;

    obs_t exp_q[$];
    int n_assert = 0, n_fail = 0;
    int m_state, m_cas_left, m_act_left, m_refi;
    logic m_cas_on;
    logic [6:0] m_first;

    function automatic obs_t cur();
        return {cmd_valid, cmd_code, cmd_arg, cmd_cas, cas_armed, err_seq,
                err_cas_orphan, err_ref_after_act, err_ref_interval};
    endfunction

    // 0 nop, 32 ACT1, 33 ACT2, 34 MRW1, 35 MRW2, otherwise the single-cycle code
    function automatic int kind(input logic c, input logic [6:0] a);
        if (!c || a == 7'b0) return 0;
        if (a ==? 7'b111????) return 32;
        if (a ==? 7'b110????) return 33;
        if (a == 7'b0001101) return 34;
        if (a ==? 7'b000100?) return 35;
        if (a == 7'b0001111) return 2;
        if (a == 7'b0001110) return 3;
        if (a ==? 7'b011????) return 4;
        if (a ==? 7'b0010???) return 5;
        if (a ==? 7'b010????) return 6;
        if (a ==? 7'b100????) return 7;
        if (a ==? 7'b101????) return 8;
        if (a ==? 7'b0011???) return 9;
        if (a ==? 7'b000011?) return 10;
        if (a == 7'b0001100) return 12;
        if (a == 7'b0001011) return 13;
        if (a == 7'b0000001) return 14;
        if (a == 7'b0000011) return 15;
        if (a == 7'b0000010) return 16;
        return 31;
    endfunction

    task automatic model_reset();
        m_state = 0; m_cas_on = 1'b0; m_cas_left = 0; m_act_left = 0; m_refi = 0; m_first = '0;
        exp_q.delete();
    endtask

    task automatic model(input logic c, input logic [6:0] a);
        obs_t e = '0;
        int k = kind(c, a);
        int out = 0;
        int nxt = 0;
        if (m_state == 1 && k == 33) begin
            out = 1; e.arg = {m_first, a};
        end else if (m_state == 2 && k == 35) begin
            out = 11; e.arg = {m_first, a};
        end else begin
            e.seq = m_state != 0;
            if (k == 32) nxt = 1;
            else if (k == 34) nxt = 2;
            else if (k == 33 || k == 35) out = 31;
            else out = k;
            if (nxt != 0) m_first = a;
            if (out != 0) e.arg = {7'b0, a};
        end
        m_state = nxt;
        e.v = out != 0;
        e.code = out[4:0];
        if (out >= 4 && out <= 8 && m_cas_on) begin
            e.cas = 1'b1; m_cas_on = 1'b0;
        end else if (out == 9) begin
            m_cas_on = 1'b1; m_cas_left = P_CASWIN;
        end else if (m_cas_on) begin
            m_cas_left--;
            if (m_cas_left == 0) begin e.orphan = 1'b1; m_cas_on = 1'b0; end
        end
        e.armed = m_cas_on;
        e.raa = out == 3 && m_act_left > 0;
        if (out == 1) m_act_left = P_ACTREF;
        else if (m_act_left > 0) m_act_left--;
        m_refi = out == 3 ? 0 : m_refi + 1;
        if (m_refi == P_REFI) begin e.rint = 1'b1; m_refi = 0; end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic cyc(input logic c, input logic [6:0] a, input string tag);
        obs_t e;
        cs = c; ca = a;
        model(c, a);
        @(posedge ck_t); #1;
        e = exp_q.pop_front();
        chk(tag, 32'(cur()), 32'(e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        chk("reset_outputs", 32'(cur()), 32'd0);
        @(negedge ck_t); ddr_reset = 1'b0;

        for (int i = 1; i < P_REFI; i++) cyc(1'b0, NOP, "refi_wait");
        cyc(1'b1, REF, "ref_at_limit");
        chk("ref_at_limit_no_int", 32'(err_ref_interval), 32'd0);
        chk("ref_at_limit_code", 32'(cmd_code), 32'd3);
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i < P_REFI; i++) cyc(1'b0, NOP, "refi_idle");
            cyc(1'b0, NOP, "refi_edge");
            chk("refi_pulse", 32'(err_ref_interval), 32'd1);
        end

        cyc(1'b1, 7'b1110101, "act1");
        chk("act1_silent", 32'(cmd_valid), 32'd0);
        cyc(1'b1, 7'b1100011, "act2");
        chk("act_valid", 32'(cmd_valid), 32'd1);
        chk("act_code", 32'(cmd_code), 32'd1);
        chk("act_arg", 32'(cmd_arg), 32'(14'b1110101_1100011));
        chk("act_no_seq", 32'(err_seq), 32'd0);
        cyc(1'b0, NOP, "gap");
        cyc(1'b0, NOP, "gap");
        cyc(1'b1, REF, "ref_early");
        chk("ref_early_code", 32'(cmd_code), 32'd3);
        chk("ref_early_err", 32'(err_ref_after_act), 32'd1);
        cyc(1'b1, 7'b1110101, "act1");
        cyc(1'b1, 7'b1100011, "act2");
        for (int i = 0; i < 6; i++) cyc(1'b0, NOP, "gap");
        cyc(1'b1, REF, "ref_late");
        chk("ref_late_err", 32'(err_ref_after_act), 32'd0);

        cyc(1'b1, 7'b1110000, "act1_broken");
        cyc(1'b0, NOP, "break_cs0");
        chk("break_seq", 32'(err_seq), 32'd1);
        cyc(1'b1, 7'b0001111, "pre");
        chk("pre_code", 32'(cmd_code), 32'd2);
        chk("pre_no_seq", 32'(err_seq), 32'd0);

        cyc(1'b1, CAS, "cas");
        chk("cas_code", 32'(cmd_code), 32'd9);
        chk("cas_armed", 32'(cas_armed), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, NOP, "cas_gap");
        cyc(1'b1, 7'b0110000, "wr16");
        chk("wr16_code", 32'(cmd_code), 32'd4);
        chk("wr16_cas", 32'(cmd_cas), 32'd1);
        cyc(1'b1, CAS, "cas_orphan");
        for (int i = 1; i < P_CASWIN; i++) cyc(1'b0, NOP, "cas_wait");
        cyc(1'b0, NOP, "cas_expire");
        chk("orphan_pulse", 32'(err_cas_orphan), 32'd1);
        chk("orphan_disarm", 32'(cas_armed), 32'd0);
        cyc(1'b1, CAS, "cas_race");
        for (int i = 1; i < P_CASWIN; i++) cyc(1'b0, NOP, "cas_wait");
        cyc(1'b1, 7'b1000000, "rd16_last");
        chk("race_cas", 32'(cmd_cas), 32'd1);
        chk("race_no_orphan", 32'(err_cas_orphan), 32'd0);

        foreach (SWEEP[i]) cyc(1'b1, SWEEP[i], "sweep");
        for (int i = 0; i < 300; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0 ? SWEEP[$urandom_range(0, 25)]
                                                                     : 7'($urandom_range(0, 127)), "random");

        cyc(1'b1, CAS, "cas_pre_reset");
        cyc(1'b1, 7'b0001101, "mrw1");
        #2 ddr_reset = 1'b1;
        #1 chk("reset_async", 32'(cur()), 32'd0);
        model_reset();
        @(posedge ck_t); #1;
        chk("reset_held", 32'(cur()), 32'd0);
        @(negedge ck_t); ddr_reset = 1'b0;
        cyc(1'b1, 7'b0001000, "lone_mrw2");
        chk("lone_mrw2_code", 32'(cmd_code), 32'd31);
        chk("lone_mrw2_no_seq", 32'(err_seq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
